// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and helpers for the memory port initiator
package mem_if_pkg;

    localparam int CMD_ADDR_W = 8;
    localparam int CMD_DATA_W = 32;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

    typedef struct packed {
        mem_op_e                op;
        logic [CMD_ADDR_W-1:0]  addr;
        logic [CMD_DATA_W-1:0]  wdata;
    } mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RD_WAIT
    } init_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_port_initiator_if.sv
// rtl/mem_port_initiator_if.sv - host command, memory port and status bundle
interface mem_port_initiator_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              mem_valid;
    logic              mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic              err_timeout;
    logic [15:0]       wr_cnt;
    logic [15:0]       rd_cnt;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, mem_ready, mem_rdata,
        output cmd_ready, mem_valid, mem_op, mem_addr, mem_wdata,
               rsp_valid, rsp_addr, rsp_data, busy, err_timeout, wr_cnt, rd_cnt
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, mem_ready, mem_rdata,
        input  cmd_ready, mem_valid, mem_op, mem_addr, mem_wdata,
               rsp_valid, rsp_addr, rsp_data, busy, err_timeout, wr_cnt, rd_cnt
    );
endinterface

// File: rtl/mem_cmd_fifo.sv
// rtl/mem_cmd_fifo.sv - synchronous command FIFO with registered ready
module mem_cmd_fifo
    import mem_if_pkg::*;
#(
    parameter type T     = mem_cmd_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic empty,
    output logic ready
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          ready_q, ready_d;
    logic          full, do_push, do_pop;
    T              mem_q [DEPTH];

    function automatic logic is_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
        return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
    endfunction

    assign full     = is_full(wr_ptr_q, rd_ptr_q);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign do_pop   = pop && !empty;
    // A pop frees the head slot, so a full FIFO may still take a push that cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q[PW-2:0]];
    assign ready    = ready_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, do_pop};
        ready_d  = !is_full(wr_ptr_d, rd_ptr_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-2:0]] <= push_data;
    end

endmodule

// File: rtl/mem_port_initiator.sv
// rtl/mem_port_initiator.sv - drives one memory port from a queued host command stream
module mem_port_initiator
    import mem_if_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_initiator_if.master bus
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(RD_LAT + 1);

    typedef struct packed {
        mem_op_e           op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    cmd_t              push_cmd, head;
    logic              fifo_empty, fifo_ready, push, pop;
    init_state_e       state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    mem_op_e           mem_op_q, mem_op_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [WW-1:0]     wait_q, wait_d, wait_inc;
    logic [LW-1:0]     lat_q, lat_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              err_q, err_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    assign push     = bus.cmd_valid && fifo_ready;
    assign push_cmd = '{op: mem_op_e'(bus.cmd_op), addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    assign wait_inc = wait_q + WW'(1);

    mem_cmd_fifo #(.T(cmd_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .ready     (fifo_ready)
    );

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_op_d    = mem_op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wait_d      = wait_q;
        lat_d       = lat_q;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    mem_valid_d = 1'b1;
                    mem_op_d    = head.op;
                    mem_addr_d  = head.addr;
                    mem_wdata_d = head.wdata;
                    wait_d      = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // Ready is checked before the timeout so a last-cycle accept is never aborted.
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (mem_op_q == OP_WRITE) begin
                        wr_cnt_d = sat_inc16(wr_cnt_q);
                        state_d  = IDLE;
                    end else begin
                        rsp_addr_d = mem_addr_q;
                        lat_d      = LW'(1);
                        state_d    = RD_WAIT;
                    end
                end else if (wait_inc == WW'(TIMEOUT)) begin
                    mem_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_inc;
                end
            end
            RD_WAIT: begin
                if (lat_q == LW'(RD_LAT)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.mem_rdata;
                    rd_cnt_d    = sat_inc16(rd_cnt_q);
                    state_d     = IDLE;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_op_q    <= OP_READ;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wait_q      <= '0;
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wait_q      <= wait_d;
            lat_q       <= lat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign bus.cmd_ready   = fifo_ready;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_op      = mem_op_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_addr    = rsp_addr_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.busy        = !fifo_empty || (state_q != IDLE);
    assign bus.err_timeout = err_q;
    assign bus.wr_cnt      = wr_cnt_q;
    assign bus.rd_cnt      = rd_cnt_q;

endmodule
